// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the sequential Karatsuba multiplier.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_Y,
    MUL_Z,
    DONE
  } state_t;

  // Low half is the larger one when N is odd.
  function automatic int lo_w(input int n);
    return n / 2 + n % 2;
  endfunction

  function automatic int hi_w(input int n);
    return n - lo_w(n);
  endfunction

  function automatic int mul_w(input int n);
    return lo_w(n) + 1;
  endfunction

endpackage

// File: rtl/karatsuba_seq_mul.sv
// Combinational W x W -> 2W unsigned multiplier shared by the Karatsuba controller.
module karatsuba_seq_mul #(
  parameter int W = 5
) (
  input  logic [W-1:0]   u,
  input  logic [W-1:0]   v,
  output logic [2*W-1:0] r
);

  assign r = (2*W)'(u) * (2*W)'(v);

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiplier behind a valid/ready stream, one shared half-width multiplier.
// Define KARATSUBA_SEQ_OPREG_EN to register the multiplier operands (two cycles per partial product).
module karatsuba_seq_ctrl
  import karatsuba_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   u,
  input  logic [N-1:0]   v,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] r,
  output logic           busy
);

  localparam int H  = lo_w(N);
  localparam int L  = hi_w(N);
  localparam int M  = mul_w(N);
  localparam int RW = 2 * N;

  state_t state, state_nx;

  logic [L-1:0]   a, c;
  logic [H-1:0]   b, d;
  logic [2*L-1:0] px;
  logic [2*H-1:0] py;
  logic [M-1:0]   sel_u, sel_v, mul_u, mul_v;
  logic [2*M-1:0] prod, zxy;
  logic [RW-1:0]  r_full;
  logic           cap;
  logic           accept;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    sel_u = '0;
    sel_v = '0;
    case (state)
      MUL_X: begin
        sel_u = M'(a);
        sel_v = M'(c);
      end
      MUL_Y: begin
        sel_u = M'(b);
        sel_v = M'(d);
      end
      MUL_Z: begin
        sel_u = M'(a) + M'(b);
        sel_v = M'(c) + M'(d);
      end
      default: ;
    endcase
  end

`ifdef KARATSUBA_SEQ_OPREG_EN
  logic [M-1:0] op_u, op_v;
  logic         phase;

  // Phase 0 issues operands into the registers, phase 1 captures the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_u  <= '0;
      op_v  <= '0;
      phase <= 1'b0;
    end else begin
      op_u  <= sel_u;
      op_v  <= sel_v;
      phase <= (state == MUL_X || state == MUL_Y || state == MUL_Z) ? ~phase : 1'b0;
    end
  end

  assign mul_u = op_u;
  assign mul_v = op_v;
  assign cap   = phase;
`else
  assign mul_u = sel_u;
  assign mul_v = sel_v;
  assign cap   = 1'b1;
`endif

  karatsuba_seq_mul #(.W(M)) u_mul (
    .u (mul_u),
    .v (mul_v),
    .r (prod)
  );

  // Middle term z-x-y is never negative, so plain modular subtraction suffices;
  // recombination mod 2^2N matches the 2N+2-bit sum truncated to 2N.
  always_comb begin
    zxy    = prod - (2*M)'(px) - (2*M)'(py);
    r_full = (RW'(px) << (2 * H)) + (RW'(zxy) << H) + RW'(py);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MUL_X;
      MUL_X:   if (cap) state_nx = MUL_Y;
      MUL_Y:   if (cap) state_nx = MUL_Z;
      MUL_Z:   if (cap) state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? MUL_X : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a  <= '0;
      b  <= '0;
      c  <= '0;
      d  <= '0;
      px <= '0;
      py <= '0;
      r  <= '0;
    end else begin
      if (accept) begin
        a <= u[N-1:H];
        b <= u[H-1:0];
        c <= v[N-1:H];
        d <= v[H-1:0];
      end
      if (state == MUL_X && cap) px <= prod[2*L-1:0];
      if (state == MUL_Y && cap) py <= prod[2*H-1:0];
      if (state == MUL_Z && cap) r  <= r_full;
    end
  end

endmodule
